// File: rtl/pixels_lost_ctrl_if.sv
// Request/result handshake bundle between a requester/consumer and pixels_lost_ctrl.
// The master side offers corner sets and takes results; the slave side is the controller.
interface pixels_lost_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [75:0] req_corners;
  logic        res_valid;
  logic        res_ready;
  logic [6:0]  res_percent;
  logic        res_over;

  modport master (
    output req_valid, req_corners, res_ready,
    input  req_ready, res_valid, res_percent, res_over
  );

  modport slave (
    input  req_valid, req_corners, res_ready,
    output req_ready, res_valid, res_percent, res_over
  );
endinterface

// File: rtl/pixels_lost_ctrl.sv
// Sequences one corner set at a time through the pixels_lost datapath, captures the
// clamped percentage after LATENCY edges and tracks the best (lowest) result seen.
module pixels_lost_ctrl #(
  parameter int LATENCY = 4,
  parameter int THRESH  = 50
) (
  input  logic                     clock,
  input  logic                     reset_n,
  pixels_lost_ctrl_if.slave        bus,
  output logic [75:0]              pl_corners,
  input  logic [6:0]               pl_percent,
  input  logic                     clear_best,
  output logic                     best_valid,
  output logic [6:0]               best_percent,
  output logic [75:0]              best_corners
);

  typedef enum logic [1:0] {IDLE, SETTLE, RESULT} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  localparam logic [6:0] THRESH_V = 7'(THRESH);
  localparam logic [6:0] PCT_MAX  = 7'd100;
  localparam logic [6:0] BEST_RST = 7'd127;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic        accept;
  logic        capture;
  logic [6:0]  clamped;
  logic        take_best;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of the order the processes are evaluated in.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can leave a
  // signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept    = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = RESULT;
        end
      end
      RESULT: begin
        if (bus.res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.res_valid = (state == RESULT);

  assign clamped = (pl_percent > PCT_MAX) ? PCT_MAX : pl_percent;

  // A coincident clear wipes the old best first, so the capture always wins then.
  assign take_best = clear_best || !best_valid || (clamped < best_percent);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt             <= 4'd0;
      pl_corners      <= '0;
      bus.res_percent <= 7'd0;
      bus.res_over    <= 1'b0;
    end else begin
      if (accept) begin
        cnt        <= CNT_INIT;
        pl_corners <= bus.req_corners;
      end else if (state == SETTLE && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (capture) begin
        bus.res_percent <= clamped;
        bus.res_over    <= (clamped > THRESH_V);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      best_valid   <= 1'b0;
      best_percent <= BEST_RST;
      best_corners <= '0;
    end else if (capture && take_best) begin
      best_valid   <= 1'b1;
      best_percent <= clamped;
      best_corners <= pl_corners;
    end else if (clear_best) begin
      best_valid   <= 1'b0;
      best_percent <= BEST_RST;
      best_corners <= '0;
    end
  end

endmodule

// File: doc/pixels_lost_ctrl.md
PIXELS_LOST_CTRL -- requirements
Module: pixels_lost_ctrl

Interface
REQ-001 Parameter LATENCY, default 4: clock edges the pixels_lost datapath needs, with stable corners, before percent_lost is valid (legal 1..15).
REQ-002 Parameter THRESH, default 50: percent-lost limit for the over-threshold flag (legal 0..100).
REQ-003 clock  in  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  requester offers a corner set.
REQ-006 req_ready  out  1  controller can accept a corner set.
REQ-007 req_corners  in  76  packed {x1[9:0],y1[8:0],x2,y2,x3,y3,x4,y4}.
REQ-008 pl_corners  out  76  same packing; drives pixels_lost x1..y4.
REQ-009 pl_percent  in  7  percent_lost returned by pixels_lost.
REQ-010 res_valid  out  1  result available.
REQ-011 res_ready  in  1  consumer takes the result.
REQ-012 res_percent  out  7  captured percent, clamped to 0..100.
REQ-013 res_over  out  1  res_percent > THRESH.
REQ-014 clear_best  in  1  single-cycle pulse; clears best-tracking.
REQ-015 best_valid  out  1  best_percent/best_corners hold a real result.
REQ-016 best_percent  out  7  lowest res_percent since reset or clear.
REQ-017 best_corners  out  76  corner set that produced best_percent.

Function
REQ-018 States: IDLE, SETTLE, RESULT; encoding free.
REQ-019 req_ready SHALL be 1 exactly when state is IDLE (combinational from state).
REQ-020 IDLE, req_valid=1 at edge N: pl_corners <= req_corners, settle counter <= LATENCY-1, state -> SETTLE.
REQ-021 pl_corners SHALL change only on accept (REQ-020) and reset; held constant through SETTLE and RESULT.
REQ-022 SETTLE: counter nonzero -> decrement; counter zero -> capture pl_percent, state -> RESULT; capture therefore at edge N+LATENCY.
REQ-023 Capture: res_percent <= min(pl_percent, 100); res_over <= (clamped value > THRESH).
REQ-024 res_valid SHALL be 1 exactly when state is RESULT; res_percent/res_over stable while res_valid=1.
REQ-025 RESULT, res_ready=1: state -> IDLE; next request acceptable one edge later (no accept in the same edge).
REQ-026 res_ready outside RESULT and req_valid outside IDLE SHALL be ignored.
REQ-027 At capture, if best_valid=0 or clamped value < best_percent: best_percent <= value, best_corners <= pl_corners, best_valid <= 1; ties keep the earlier set.
REQ-028 clear_best=1 with no capture in that edge: best_valid <= 0, best_percent <= 127, best_corners <= 0.
REQ-029 clear_best coincident with a capture: clear applies first, then the capture is recorded (best_valid=1, best = captured set).
REQ-030 Comparison and clamp SHALL be unsigned 7-bit; no other arithmetic on corner fields.

Reset
REQ-031 reset_n=0 SHALL immediately force: state IDLE, counter 0, pl_corners 0, res_percent 0, res_over 0, best_valid 0, best_percent 127, best_corners 0; hence req_ready=1, res_valid=0.
REQ-032 Reset during SETTLE or RESULT SHALL discard the in-flight set and result; no res_valid pulse after release.
REQ-033 After reset_n rises, first accept is allowed on the next rising edge.

Verification
REQ-034 Square x=80/160, y=80/160 (x1=80,y1=80,x2=80,y2=160,x3=160,y3=160,x4=160,y4=80), stub pl_percent=0, LATENCY=4: accept edge N -> res_valid rises edge N+4, res_percent=0, res_over=0, best_valid=1, best_corners=packed square.
REQ-035 Stub pl_percent=75, THRESH=50 -> res_percent=75, res_over=1; res_ready held 0 for 10 cycles -> res_valid, outputs, pl_corners stable; req_ready=0 throughout.
REQ-036 Stub pl_percent=120 -> res_percent=100, res_over=1; sequence 40,20,20,60 -> best_percent=20 with corners of the first 20 set.
REQ-037 clear_best pulsed on the capture edge of a 30% result after best=10 -> best_valid=1, best_percent=30.
REQ-038 reset_n low for one cycle mid-SETTLE (counter=2) -> all outputs at REQ-031 values at once, no res_valid afterwards; new request accepted and completes in LATENCY edges.
REQ-039 LATENCY=1, back-to-back req_valid with res_ready tied 1 -> one result every 3 edges, values in request order.
